// File: rtl/inv_mod_multi.sv
// Multi-cycle modular inverse: Kaliski almost-inverse phase, then a halving or
// doubling correction phase selects plain, Montgomery or Montgomery-domain form.
module inv_mod_multi #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opM,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  localparam int W  = DATA_WIDTH;
  localparam int RW = W + 2;
  localparam int KW = $clog2(2 * W + 1);
  localparam logic [KW-1:0] WK  = KW'(W);
  localparam logic [KW-1:0] W2K = KW'(2 * W);

  typedef enum logic [2:0] {IDLE, PH1, FIX, PH2, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    u_q, u_d, v_q, v_d, m_q, m_d, data_q, data_d;
  logic [RW-1:0]   r_q, r_d, s_q, s_d;
  logic [KW-1:0]   k_q, k_d, n_q, n_d;
  logic [1:0]      mode_q, mode_d;
  logic            halve_q, halve_d, err_q, err_d;

  logic [RW-1:0]   mExt, rRed, rFix, rSum, rDbl, rStep;
  logic [KW-1:0]   nFix;
  logic            halveFix, reject;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;

  // r leaves PH1 in [0, 2M); reduce once and negate to get A^-1 * 2^k mod M.
  assign mExt  = {2'b00, m_q};
  assign rRed  = (r_q >= mExt) ? r_q - mExt : r_q;
  assign rFix  = mExt - rRed;
  assign rSum  = r_q + mExt;
  assign rDbl  = {r_q[RW-2:0], 1'b0};
  assign rStep = halve_q ? (r_q[0] ? (rSum >> 1) : (r_q >> 1))
                         : ((rDbl >= mExt) ? rDbl - mExt : rDbl);

  assign reject = (opA == '0) || !opM[0] || (opM < W'(3)) || (opA >= opM) ||
                  (mode == 2'd3);

  always_comb begin
    nFix     = '0;
    halveFix = 1'b0;
    case (mode_q)
      2'd0: begin
        halveFix = 1'b1;
        nFix     = k_q;
      end
      2'd1: begin
        if (k_q > WK) begin
          halveFix = 1'b1;
          nFix     = k_q - WK;
        end else begin
          nFix = WK - k_q;
        end
      end
      default: nFix = W2K - k_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    m_d     = m_q;
    r_d     = r_q;
    s_d     = s_q;
    k_d     = k_q;
    n_d     = n_q;
    mode_d  = mode_q;
    halve_d = halve_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d    = opM;
          mode_d = mode;
          u_d    = opM;
          v_d    = opA;
          s_d    = RW'(1);
          r_d    = '0;
          k_d    = '0;
          data_d = '0;
          err_d  = reject;
          state_d = reject ? DONE : PH1;
        end
      end
      PH1: begin
        if (v_q == '0) begin
          if (u_q != W'(1)) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = DONE;
          end else begin
            state_d = FIX;
          end
        end else begin
          k_d = k_q + KW'(1);
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            s_d = s_q << 1;
          end else if (!v_q[0]) begin
            v_d = v_q >> 1;
            r_d = r_q << 1;
          end else if (u_q > v_q) begin
            u_d = (u_q - v_q) >> 1;
            r_d = r_q + s_q;
            s_d = s_q << 1;
          end else begin
            v_d = (v_q - u_q) >> 1;
            s_d = s_q + r_q;
            r_d = r_q << 1;
          end
        end
      end
      FIX: begin
        r_d     = rFix;
        n_d     = nFix;
        halve_d = halveFix;
        if (nFix == '0) begin
          data_d  = rFix[W-1:0];
          state_d = DONE;
        end else begin
          state_d = PH2;
        end
      end
      PH2: begin
        r_d = rStep;
        n_d = n_q - KW'(1);
        if (n_q == KW'(1)) begin
          data_d  = rStep[W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      mode_q  <= '0;
      halve_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      m_q     <= m_d;
      r_q     <= r_d;
      s_q     <= s_d;
      k_q     <= k_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      halve_q <= halve_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_inv_mod_multi.sv
// Bench for inv_mod_multi: 8-bit and 16-bit instances share one stimulus bus,
// selected by sel; expected results travel through a scoreboard queue.
module tb_inv_mod_multi;

  logic        clk = 1'b0;
  logic        rst, inValid, outReady, sel;
  logic [15:0] opAB, opMB;
  logic [1:0]  modeB;
  logic        ir8, ov8, oe8, ir16, ov16, oe16;
  logic [7:0]  od8;
  logic [15:0] od16;
  logic        inReady, outValid, outErr;
  logic [15:0] outData;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
    string       name;
  } exp_t;
  exp_t sbQ[$];

  typedef struct {
    string  name;
    bit     which;
    int     a;
    int     m;
    int     md;
    longint expData;
    bit     expErr;
    int     expLat;
  } vec_t;

  always #5 clk = ~clk;

  assign inReady  = sel ? ir16 : ir8;
  assign outValid = sel ? ov16 : ov8;
  assign outErr   = sel ? oe16 : oe8;
  assign outData  = sel ? od16 : {8'h00, od8};

  inv_mod_multi #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid & ~sel), .in_ready(ir8),
    .opA(opAB[7:0]), .opM(opMB[7:0]), .mode(modeB), .out_valid(ov8),
    .out_ready(outReady & ~sel), .out_data(od8), .out_err(oe8));

  inv_mod_multi #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid & sel), .in_ready(ir16),
    .opA(opAB), .opM(opMB), .mode(modeB), .out_valid(ov16),
    .out_ready(outReady & sel), .out_data(od16), .out_err(oe16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Extended Euclid, then scale by 2^(md*w) with modular doublings.
  task automatic refModel(input longint a, input longint m, input int md, input int w,
                          output longint res, output bit err);
    longint t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = m; nr = a;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    err = (r != 1);
    if (t < 0) t += m;
    for (int i = 0; i < md * w; i++) t = (t * 2) % m;
    res = err ? 0 : t;
  endtask

  task automatic driveInput(input bit which, input int a, input int m, input int md);
    int guard = 0;
    @(negedge clk);
    sel = which;
    while (!inReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!inReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait: in_ready got 0, want 1");
    end
    opAB = 16'(a);
    opMB = 16'(m);
    modeB = 2'(md);
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic applyStimulus(input bit which, input int a, input int m, input int md,
                               input string name, input longint expData, input bit expErr,
                               output int lat);
    sbQ.push_back('{data: 64'(expData), err: expErr, name: name});
    driveInput(which, a, m, md);
    lat = 1;
    while (!outValid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!outValid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: out_valid got 0, want 1 within 300 cycles", name);
      lat = -1;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, want an entry");
    end else begin
      e = sbQ.pop_front();
      check({e.name, "_data"}, 64'(outData), e.data);
      check({e.name, "_err"}, 64'(outErr), 64'(e.err));
    end
  endtask

  task automatic retire(input string name);
    outReady = 1'b1;
    inValid  = 1'b0;
    @(negedge clk);
    outReady = 1'b0;
    check({name, "_retire_valid"}, 64'(outValid), 64'd0);
    check({name, "_retire_ready"}, 64'(inReady), 64'd1);
  endtask

  initial begin
    vec_t   vecs[$];
    int     lat;
    longint expD;
    bit     expE;

    vecs = '{
      '{"m0_3_11",   0, 3,   11,  0, 4,   0, 13},
      '{"m1_3_11",   0, 3,   11,  1, 1,   0, 11},
      '{"m2_3_11",   0, 3,   11,  2, 3,   0, 19},
      '{"gcd_6_9",   0, 6,   9,   0, 0,   1, 5},
      '{"evenM_3_10",0, 3,   10,  0, 0,   1, 1},
      '{"one_251",   0, 1,   251, 0, 1,   0, 0},
      '{"neg1_251",  0, 250, 251, 0, 250, 0, 0},
      '{"m1_1_251",  0, 1,   251, 1, 5,   0, 0},
      '{"m2_1_251",  0, 1,   251, 2, 25,  0, 0},
      '{"zeroA",     0, 0,   11,  0, 0,   1, 1},
      '{"AgeM",      0, 11,  11,  0, 0,   1, 1},
      '{"mode3",     0, 3,   11,  3, 0,   1, 1},
      '{"w16_m0",    1, 3,   11,  0, 4,   0, 13},
      '{"w16_m1",    1, 3,   11,  1, 3,   0, 19}
    };

    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; sel = 1'b0;
    opAB = '0; opMB = '0; modeB = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      sel = w[0];
      #1;
      check($sformatf("reset%0d_ready", w), 64'(inReady), 64'd1);
      check($sformatf("reset%0d_valid", w), 64'(outValid), 64'd0);
      check($sformatf("reset%0d_data", w), 64'(outData), 64'd0);
      check($sformatf("reset%0d_err", w), 64'(outErr), 64'd0);
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].which, vecs[i].a, vecs[i].m, vecs[i].md, vecs[i].name,
                    vecs[i].expData, vecs[i].expErr, lat);
      checkOutput();
      if (vecs[i].expLat != 0) check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].expLat));
      retire(vecs[i].name);
    end

    // Result held under backpressure while a competing request is ignored.
    applyStimulus(0, 3, 11, 0, "hold", 4, 0, lat);
    opAB = 16'd5; opMB = 16'd7; modeB = 2'd1; inValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold_data_c%0d", c), 64'(outData), 64'd4);
      check($sformatf("hold_ready_c%0d", c), 64'(inReady), 64'd0);
    end
    checkOutput();
    retire("hold");
    repeat (3) @(negedge clk);
    check("hold_no_ghost", 64'(outValid), 64'd0);

    // Reset in the middle of the almost-inverse phase.
    driveInput(0, 3, 11, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 64'(outValid), 64'd0);
    check("midrst_ready", 64'(inReady), 64'd1);
    check("midrst_err", 64'(outErr), 64'd0);
    repeat (20) @(negedge clk);
    check("midrst_no_result", 64'(outValid), 64'd0);
    applyStimulus(0, 3, 11, 0, "after_rst", 4, 0, lat);
    checkOutput();

    // Reset while a finished result is waiting clears it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("donerst_valid", 64'(outValid), 64'd0);
    check("donerst_data", 64'(outData), 64'd0);
    check("donerst_ready", 64'(inReady), 64'd1);

    for (int i = 0; i < 40; i++) begin
      int m, a, md, g;
      md = int'($urandom_range(2, 0));
      if (i % 4 == 3) begin
        g = (i % 3 == 0) ? 3 : ((i % 3 == 1) ? 5 : 7);
        m = g * int'($urandom_range(9000, 3) | 1);
        a = g * int'($urandom_range(m / g - 1, 1));
      end else begin
        m = int'($urandom_range(65535, 3) | 1);
        a = int'($urandom_range(m - 1, 1));
      end
      refModel(a, m, md, 16, expD, expE);
      applyStimulus(1, a, m, md, $sformatf("rnd%0d_a%0d_m%0d_md%0d", i, a, m, md),
                    expD, expE, lat);
      checkOutput();
      retire($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
